uart_word_tx_framer: RTL and testbench

- Sits between the BIP datapath and uart_tx on the transmit side of top.
- Buffers 16-bit result words (accumulator and data-memory dumps) in a small FIFO.
- Sends each word as two bytes, low byte first, using uart_tx's start/done handshake.
- The byte order matches the host-side reassembly: first received byte is [7:0], second is [15:8].

---
 rtl/uart_word_tx_framer.sv | 150 +++++++++++++++
 tb/tb_uart_word_tx_framer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx_framer.sv
// uart_word_tx_framer
// Queues 16-bit result words in a small FIFO and hands each word to uart_tx
// as two bytes, low byte first, using the start/done handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no word in flight; pops the FIFO head when one is queued
// ST_WAIT_LO | low byte started, waiting for uart_tx to finish it
// ST_WAIT_HI | high byte started, waiting for uart_tx to finish it
module uart_word_tx_framer #(
  parameter int NBITS_D    = 16,
  parameter int DBIT       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NBITS_D-1:0] i_data,
  output logic               o_ready,
  output logic               o_tx_start,
  output logic [DBIT-1:0]    o_tx_data,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_word_done,
  output logic [PTR_W:0]     o_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LO = 2'd1,
    ST_WAIT_HI = 2'd2
  } state_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [NBITS_D-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;

  state_t             state_q, state_d;
  logic [NBITS_D-1:0] word_q, word_d;
  logic               start_q, start_d;
  logic [DBIT-1:0]    data_q, data_d;
  logic               busy_q, busy_d;
  logic               wdone_q, wdone_d;

  logic               push;
  logic               pop;
  logic               done_ok;

  assign o_ready = (count_q != FULL_CNT);
  assign push    = i_valid && o_ready;
  // A done pulse that lines up with our own start pulse still belongs to the
  // previous byte, so it must not advance the engine.
  assign done_ok = i_tx_done && !start_q;

  assign o_tx_start  = start_q;
  assign o_tx_data   = data_q;
  assign o_busy      = busy_q;
  assign o_word_done = wdone_q;
  assign o_count     = count_q;

  // FIFO storage: entries need no reset, the pointers define what is valid
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_data;
  end

  // Occupancy after this cycle's push and pop
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  // FIFO pointers and count; reset drops everything queued
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Next state and next registered outputs of the byte engine
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    start_d = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q;
    wdone_d = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          word_d  = mem[rd_ptr_q];
          data_d  = mem[rd_ptr_q][DBIT-1:0];
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (done_ok) begin
          data_d  = word_q[NBITS_D-1:DBIT];
          start_d = 1'b1;
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (done_ok) begin
          wdone_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Engine state and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      wdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      start_q <= start_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      wdone_q <= wdone_d;
    end
  end

endmodule

// File: tb/tb_uart_word_tx_framer.sv
// Testbench for uart_word_tx_framer: a directed vector table for the
// handshake corner cases, then randomized traffic against a word-queue model.
module tb_uart_word_tx_framer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] data;
  logic        ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        word_done;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_word_tx_framer #(
    .NBITS_D(16), .DBIT(8), .FIFO_DEPTH(DEPTH), .PTR_W(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
    .o_ready(ready), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_done(tx_done), .o_busy(busy), .o_word_done(word_done),
    .o_count(count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] data;
    logic        done;
    logic        e_start;
    logic [7:0]  e_data;
    logic        chk_data;
    logic        e_busy;
    logic        e_wdone;
    logic [2:0]  e_count;
    logic        e_ready;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [15:0] d,
                              input logic dn, input logic es, input logic [7:0] ed,
                              input logic cd, input logic eb, input logic ew,
                              input logic [2:0] ec, input logic er);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.done = dn;
    t.e_start = es; t.e_data = ed; t.chk_data = cd;
    t.e_busy = eb; t.e_wdone = ew; t.e_count = ec; t.e_ready = er;
    return t;
  endfunction

  localparam int NV = 26;
  vec_t vecs [NV];

  // Reference model state for the random phase
  logic [15:0] m_q [$];
  int          m_count;
  int          phase;     // 0: no word in flight, 1: low byte out, 2: high byte out
  int          pend;      // cycles until the responder answers the current byte
  logic [15:0] hold;
  logic [7:0]  last_byte;
  logic [7:0]  e_byte;
  bit          lo_next, hi_next, wd_next, e_start, e_wd;
  bit          d_rst, d_valid, d_done, d_push;
  logic [15:0] d_data;
  int          words_done;

  initial begin
    // row: rst valid data done | start data chk_data busy wdone count ready
    vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 3'd0, 1);
    vecs[1]  = mk(0, 1, 16'hA55A, 0, 0, 8'h00, 1, 0, 0, 3'd1, 1);
    vecs[2]  = mk(0, 0, 16'h0000, 1, 1, 8'h5A, 1, 1, 0, 3'd0, 1);
    vecs[3]  = mk(0, 0, 16'h0000, 1, 0, 8'h5A, 1, 1, 0, 3'd0, 1);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 8'h5A, 1, 1, 0, 3'd0, 1);
    vecs[5]  = mk(0, 0, 16'h0000, 1, 1, 8'hA5, 1, 1, 0, 3'd0, 1);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 8'hA5, 1, 1, 0, 3'd0, 1);
    vecs[7]  = mk(0, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 1, 3'd0, 1);
    vecs[8]  = mk(0, 1, 16'h1234, 1, 0, 8'h00, 0, 0, 0, 3'd1, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 1, 8'h34, 1, 1, 0, 3'd0, 1);
    vecs[10] = mk(1, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 3'd0, 1);
    vecs[11] = mk(0, 1, 16'h0001, 0, 0, 8'h00, 1, 0, 0, 3'd1, 1);
    vecs[12] = mk(0, 1, 16'h0002, 0, 1, 8'h01, 1, 1, 0, 3'd1, 1);
    vecs[13] = mk(0, 1, 16'h0003, 0, 0, 8'h01, 1, 1, 0, 3'd2, 1);
    vecs[14] = mk(0, 1, 16'h0004, 0, 0, 8'h01, 1, 1, 0, 3'd3, 1);
    vecs[15] = mk(0, 1, 16'h0005, 0, 0, 8'h01, 1, 1, 0, 3'd4, 0);
    vecs[16] = mk(0, 1, 16'h0006, 0, 0, 8'h01, 1, 1, 0, 3'd4, 0);
    vecs[17] = mk(0, 0, 16'h0000, 1, 1, 8'h00, 1, 1, 0, 3'd4, 0);
    vecs[18] = mk(0, 0, 16'h0000, 1, 0, 8'h00, 1, 1, 0, 3'd4, 0);
    vecs[19] = mk(0, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 1, 3'd4, 0);
    vecs[20] = mk(0, 0, 16'h0000, 0, 1, 8'h02, 1, 1, 0, 3'd3, 1);
    vecs[21] = mk(0, 0, 16'h0000, 1, 0, 8'h02, 1, 1, 0, 3'd3, 1);
    vecs[22] = mk(0, 0, 16'h0000, 1, 1, 8'h00, 1, 1, 0, 3'd3, 1);
    vecs[23] = mk(1, 1, 16'h0077, 0, 0, 8'h00, 1, 0, 0, 3'd0, 1);
    vecs[24] = mk(0, 0, 16'h0000, 1, 0, 8'h00, 1, 0, 0, 3'd0, 1);
    vecs[25] = mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 3'd0, 1);

    rst = 1'b1; valid = 1'b0; data = '0; tx_done = 1'b0;

    // Directed vectors: drive on the falling edge, check just after the rising edge
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; valid = vecs[i].valid; data = vecs[i].data; tx_done = vecs[i].done;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_start", i), int'(tx_start), int'(vecs[i].e_start));
      if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), int'(tx_data), int'(vecs[i].e_data));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      chk($sformatf("v%0d_wdone", i), int'(word_done), int'(vecs[i].e_wdone));
      chk($sformatf("v%0d_count", i), int'(count), int'(vecs[i].e_count));
      chk($sformatf("v%0d_ready", i), int'(ready), int'(vecs[i].e_ready));
    end

    // Randomized traffic; the first driven cycle resets DUT and model together
    m_count = 0; phase = 0; pend = 0; hold = '0; last_byte = '0; e_byte = '0;
    lo_next = 0; hi_next = 0; wd_next = 0; words_done = 0;
    d_rst = 1; d_valid = 0; d_done = 0; d_push = 0; d_data = '0;
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; data = '0; tx_done = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      // Advance the model across the rising edge that just happened
      if (d_rst) begin
        m_q.delete();
        m_count = 0; phase = 0; pend = 0; last_byte = '0;
        e_start = 0; e_wd = 0;
      end else begin
        e_start = 0;
        e_wd    = wd_next;
        if (hi_next) begin
          e_start = 1; e_byte = hold[15:8]; phase = 2;
        end else if (lo_next) begin
          hold = m_q.pop_front();
          m_count--;
          e_start = 1; e_byte = hold[7:0]; phase = 1;
        end
        if (d_push) begin
          m_q.push_back(d_data);
          m_count++;
        end
        if (e_wd) begin
          phase = 0;
          words_done++;
        end
      end

      chk("rnd_start", int'(tx_start), int'(e_start));
      if (e_start) begin
        chk("rnd_byte", int'(tx_data), int'(e_byte));
        last_byte = e_byte;
        pend = $urandom_range(1, 10);
      end else if (phase != 0) begin
        chk("rnd_data_stable", int'(tx_data), int'(last_byte));
      end
      chk("rnd_word_done", int'(word_done), int'(e_wd));
      chk("rnd_busy", int'(busy), int'(phase != 0));
      chk("rnd_count", int'(count), m_count);
      chk("rnd_ready", int'(ready), int'(m_count != DEPTH));

      // Choose inputs for the next edge
      d_rst   = ($urandom_range(0, 299) == 0);
      hi_next = 0;
      wd_next = 0;
      d_done  = 0;
      if (!e_start && pend > 0) begin
        pend--;
        if (pend == 0) begin
          d_done = 1;
          if (phase == 1) hi_next = 1;
          else            wd_next = 1;
        end
      end
      // Stray done pulses: only where the engine must ignore them
      if (!d_done && (phase == 0 || e_start) && $urandom_range(0, 5) == 0) d_done = 1;
      if (((cyc / 256) % 2) == 0) d_valid = ($urandom_range(0, 3) != 0);
      else                        d_valid = ($urandom_range(0, 7) == 0);
      d_data  = 16'($urandom);
      d_push  = d_valid && (m_count != DEPTH) && !d_rst;
      lo_next = !d_rst && (phase == 0) && (m_count != 0);
      if (d_rst) begin
        hi_next = 0;
        wd_next = 0;
      end
      rst = d_rst; valid = d_valid; data = d_data; tx_done = d_done;
    end

    chk("rnd_words_completed_nonzero", int'(words_done > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
